// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the LSU-to-byte-bus bridge: FSM states,
// store lane masks and the fill pattern returned by a timed-out load.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BEAT_HI = 3'd1,
    BEAT_LO = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } bridge_state_e;

  localparam logic [1:0]  MASK_HI      = 2'b10;
  localparam logic [1:0]  MASK_LO      = 2'b01;
  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;

  function automatic logic lane_on(input logic [1:0] m, input logic [1:0] lane);
    return (m & lane) != 2'b00;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Per-beat ack wait counter: held at zero while clear is high, otherwise counts
// up and raises expired in the LIMIT-th cycle of a beat.
module bus_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_byte_bridge.sv
// Executes one 16-bit big-endian LSU load/store as one or two 8-bit req/ack
// beats. Optional ack timeout is enabled with MEM_BYTE_BRIDGE_TIMEOUT_EN.
module mem_byte_bridge
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  mask,
  input  logic        write,
  output logic [15:0] rdata,
  output logic        valid,
  output logic        ext_req,
  output logic [31:0] ext_addr,
  output logic        ext_we,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        err
);

  // Handshake: a beat is in flight while ext_req=1; address, strobe and write
  // byte stay constant until the cycle in which ext_ack=1 is sampled. ext_ack
  // with ext_req=0 has no effect. On the LSU side req is a level that must be
  // seen low once after the valid pulse before a new request is accepted.

  bridge_state_e state;
  logic [31:0]   addr_q;
  logic [15:0]   wdata_q;
  logic [1:0]    mask_q;
  logic          write_q;
  logic          beat_abort;

`ifdef MEM_BYTE_BRIDGE_TIMEOUT_EN
  logic expired;

  // Counter restarts whenever no beat is pending or a beat just completed.
  bus_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!ext_req || ext_ack),
    .expired (expired)
  );

  assign beat_abort = expired && !ext_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= beat_abort && ((state == BEAT_HI) || (state == BEAT_LO));
    end
  end
`else
  logic unused_timeout_cfg;

  assign beat_abort         = 1'b0;
  assign err                = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ (TIMEOUT_FILL == 16'h0000);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
      rdata     <= '0;
      valid     <= 1'b0;
      ext_req   <= 1'b0;
      ext_addr  <= '0;
      ext_we    <= 1'b0;
      ext_wdata <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            mask_q  <= mask;
            write_q <= write;
            if (!write || lane_on(mask, MASK_HI)) begin
              state     <= BEAT_HI;
              ext_req   <= 1'b1;
              ext_addr  <= addr;
              ext_we    <= write;
              ext_wdata <= wdata[15:8];
            end else if (lane_on(mask, MASK_LO)) begin
              state     <= BEAT_LO;
              ext_req   <= 1'b1;
              ext_addr  <= addr + 32'd1;
              ext_we    <= write;
              ext_wdata <= wdata[7:0];
            end else begin
              state <= RESP;
              valid <= 1'b1;
            end
          end
        end

        BEAT_HI: begin
          if (beat_abort) begin
            state   <= RESP;
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            valid   <= 1'b1;
            if (!write_q) rdata <= TIMEOUT_FILL;
          end else if (ext_ack) begin
            if (!write_q) rdata[15:8] <= ext_rdata;
            // Loads always fetch both bytes regardless of mask.
            if (!write_q || lane_on(mask_q, MASK_LO)) begin
              state     <= BEAT_LO;
              ext_addr  <= addr_q + 32'd1;
              ext_wdata <= wdata_q[7:0];
            end else begin
              state   <= RESP;
              ext_req <= 1'b0;
              ext_we  <= 1'b0;
              valid   <= 1'b1;
            end
          end
        end

        BEAT_LO: begin
          if (beat_abort) begin
            state   <= RESP;
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            valid   <= 1'b1;
            if (!write_q) rdata <= TIMEOUT_FILL;
          end else if (ext_ack) begin
            if (!write_q) rdata[7:0] <= ext_rdata;
            state   <= RESP;
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            valid   <= 1'b1;
          end
        end

        RESP: begin
          state <= RELEASE;
        end

        RELEASE: begin
          if (!req) state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Self-checking bench for mem_byte_bridge: byte-bus responder with wait states,
// expected-beat scoreboard and a reference memory model.
module tb_mem_byte_bridge;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int          W          = 41;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  mask = '0;
  logic        write = 1'b0;
  logic [15:0] rdata;
  logic        valid;
  logic        ext_req;
  logic [31:0] ext_addr;
  logic        ext_we;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        err;

  mem_byte_bridge #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .mask      (mask),
    .write     (write),
    .rdata     (rdata),
    .valid     (valid),
    .ext_req   (ext_req),
    .ext_addr  (ext_addr),
    .ext_we    (ext_we),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  ref_mem[256];
  int          wait_states = 0;
  int          wait_cnt = 0;
  bit          ack_en = 1'b1;
  bit          spurious = 1'b0;
  logic [15:0] exp_rdata = '0;

  // Byte-bus responder: checks every in-flight beat cycle against the head of
  // the expected queue, acks after wait_states cycles and pops the entry.
  initial begin
    logic [W-1:0] e;
    ext_ack   = 1'b0;
    ext_rdata = '0;
    forever begin
      @(negedge clk);
      ext_ack   = 1'b0;
      ext_rdata = 8'($urandom);
      if (ext_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got addr=%h we=%b wdata=%h, required no beat",
                   ext_addr, ext_we, ext_wdata);
        end else begin
          e = exp_q[0];
          if ({ext_addr, ext_we, ext_wdata} !== e) begin
            errors++;
            $display("FAIL beat: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     ext_addr, ext_we, ext_wdata, e[40:9], e[8], e[7:0]);
          end
        end
        if (ack_en && wait_cnt >= wait_states) begin
          ext_ack   = 1'b1;
          ext_rdata = mem[ext_addr[7:0]];
          if (ext_we) mem[ext_addr[7:0]] = ext_wdata;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        ext_ack  = spurious;
      end
    end
  end

  // Drives one LSU transaction starting at a negedge and returns at a negedge
  // with req low and the bridge back in IDLE.
  task automatic do_op(input logic [31:0] a, input logic [15:0] wd, input logic [1:0] m,
                       input logic w, input int waits, input int hold, input bit scramble);
    int          nbeats;
    int          exp_cyc;
    int          cyc;
    bit          seen;
    logic [31:0] a1;
    a1      = a + 32'd1;
    nbeats  = 0;
    wait_states = waits;
    if (!w || m[1]) begin exp_q.push_back({a, w, wd[15:8]}); nbeats++; end
    if (!w || m[0]) begin exp_q.push_back({a1, w, wd[7:0]}); nbeats++; end
    if (!w) begin
      exp_rdata = {ref_mem[a[7:0]], ref_mem[a1[7:0]]};
    end else begin
      if (m[1]) ref_mem[a[7:0]]  = wd[15:8];
      if (m[0]) ref_mem[a1[7:0]] = wd[7:0];
    end
    exp_cyc = nbeats * (waits + 1) + 1;
    req = 1'b1; addr = a; wdata = wd; mask = m; write = w;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 1) begin
        addr = $urandom; wdata = 16'($urandom); mask = 2'($urandom); write = 1'($urandom);
      end
      seen = valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL valid_timeout: got no valid in %0d cycles, required cycle %0d", cyc, exp_cyc);
    end else if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL valid_latency: got cycle %0d, required cycle %0d", cyc, exp_cyc);
    end
    if (seen) begin
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rdata: got %h, required %h", rdata, exp_rdata);
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_clean: got %b, required 0", err);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL beats_missing: got %0d beats outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || ext_req !== 1'b0) begin
        errors++;
        $display("FAIL release_hold: got valid=%b ext_req=%b, required 0/0", valid, ext_req);
      end
    end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || ext_req !== 1'b0) begin
      errors++;
      $display("FAIL release_drop: got valid=%b ext_req=%b, required 0/0", valid, ext_req);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({valid, ext_req, ext_we, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/ext_req/ext_we/err=%b, required 0000",
               {valid, ext_req, ext_we, err});
    end
    checks++;
    if (rdata !== 16'h0 || ext_addr !== 32'h0 || ext_wdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h ext_addr=%h ext_wdata=%h, required zeros",
               rdata, ext_addr, ext_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    do_op(32'h0001_0010, 16'h0000, 2'b00, 1'b0, 0, 1, 1'b0);
    checks++;
    if (rdata !== 16'hABCD) begin
      errors++;
      $display("FAIL load_abcd: got %h, required abcd", rdata);
    end
  endtask

  task automatic test_store_word();
    do_op(32'h0000_0030, 16'h1234, 2'b11, 1'b1, 2, 1, 1'b1);
    do_op(32'h0000_0030, 16'h0000, 2'b11, 1'b0, 1, 1, 1'b0);
    checks++;
    if (rdata !== 16'h1234) begin
      errors++;
      $display("FAIL store_word_readback: got %h, required 1234", rdata);
    end
  endtask

  task automatic test_byte_stores();
    do_op(32'h0000_0020, 16'h5A00, 2'b10, 1'b1, 0, 1, 1'b0);
    do_op(32'h0000_0020, 16'h0077, 2'b01, 1'b1, 1, 1, 1'b0);
    do_op(32'h0000_0020, 16'hFFFF, 2'b00, 1'b1, 0, 1, 1'b0);
    do_op(32'h0000_0020, 16'h0000, 2'b00, 1'b0, 0, 1, 1'b0);
    checks++;
    if (rdata !== 16'h5A77) begin
      errors++;
      $display("FAIL byte_store_readback: got %h, required 5a77", rdata);
    end
  endtask

  task automatic test_wrap_release();
    do_op(32'hFFFF_FFFF, 16'h0000, 2'b11, 1'b0, 0, 3, 1'b0);
    checks++;
    if (rdata !== {ref_mem[8'hFF], ref_mem[8'h00]}) begin
      errors++;
      $display("FAIL wrap_rdata: got %h, required %h", rdata, {ref_mem[8'hFF], ref_mem[8'h00]});
    end
  endtask

  task automatic test_spurious_ack();
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ext_req !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_ack: got ext_req=%b valid=%b, required 0/0", ext_req, valid);
      end
    end
    spurious = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      do_op($urandom, 16'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(0, 2), $urandom_range(1, 3), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_beat();
    ack_en = 1'b0;
    exp_q.push_back({32'h0000_0040, 1'b0, 8'h00});
    req = 1'b1; addr = 32'h0000_0040; wdata = 16'h0000; mask = 2'b11; write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ext_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat_req: got ext_req=%b, required 1", ext_req);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ext_req !== 1'b0 || valid !== 1'b0 || rdata !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got ext_req=%b valid=%b rdata=%h, required 0/0/0000",
               ext_req, valid, rdata);
    end
    req = 1'b0;
    ack_en = 1'b1;
    exp_q.delete();
    exp_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(32'h0001_0010, 16'h0000, 2'b01, 1'b0, 1, 1, 1'b0);
    checks++;
    if (rdata !== 16'hABCD) begin
      errors++;
      $display("FAIL post_reset_load: got %h, required abcd", rdata);
    end
  endtask

`ifdef MEM_BYTE_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    ack_en = 1'b0;
    exp_q.push_back({32'h0000_0050, 1'b0, 8'h00});
    req = 1'b1; addr = 32'h0000_0050; wdata = 16'h0000; mask = 2'b11; write = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= int'(TB_TIMEOUT); c++) begin
      @(negedge clk);
      checks++;
      if (ext_req !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait: cycle %0d got ext_req=%b valid=%b, required 1/0", c, ext_req, valid);
      end
    end
    @(negedge clk);
    checks++;
    if (ext_req !== 1'b0 || valid !== 1'b1 || err !== 1'b1 || rdata !== 16'hDEAD) begin
      errors++;
      $display("FAIL timeout_abort: got ext_req=%b valid=%b err=%b rdata=%h, required 0/1/1/dead",
               ext_req, valid, err, rdata);
    end
    exp_rdata = 16'hDEAD;
    exp_q.delete();
    ack_en = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got valid=%b err=%b, required 0/0", valid, err);
    end
    req = 1'b0;
    @(negedge clk);
    do_op(32'h0000_0030, 16'h0000, 2'b11, 1'b0, 0, 1, 1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hAB; ref_mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD; ref_mem[8'h11] = 8'hCD;

    test_reset();
    test_load();
    test_store_word();
    test_byte_stores();
    test_wrap_release();
    test_spurious_ack();
    test_back_to_back();
    test_reset_mid_beat();
`ifdef MEM_BYTE_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
